// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC generation and IF/ID pipeline register for the MIPS datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
    parameter int                    MEMORY_DEPTH = 'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  BranchTaken_i,
    input  logic [DATA_WIDTH-1:0] BranchTarget_i,
    input  logic                  Jump_i,
    input  logic [DATA_WIDTH-1:0] JumpTarget_i,
    input  logic                  JumpReg_i,
    input  logic [DATA_WIDTH-1:0] JumpRegTarget_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC4_o,
    output logic                  IF_ID_Valid_o,
    output logic                  AddressError_o
);

    localparam logic [DATA_WIDTH-1:0] c_nop     = '0;
    localparam logic [DATA_WIDTH-1:0] c_last_pc = RESET_PC
                                                + DATA_WIDTH'(4 * MEMORY_DEPTH)
                                                - DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc4;
    logic                  r_valid;
    logic                  r_addr_err;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_redirect;
    logic                  w_pc_legal;
    logic                  w_next_legal;

    function automatic logic f_legal(input logic [DATA_WIDTH-1:0] a);
        return (a >= RESET_PC) && (a <= c_last_pc) && (a[1:0] == 2'b00);
    endfunction

    assign w_pc_plus4   = r_pc + DATA_WIDTH'(4);
    assign w_redirect   = JumpReg_i | Jump_i | BranchTaken_i;
    assign w_pc_legal   = f_legal(r_pc);
    assign w_next_legal = f_legal(w_next_pc);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (JumpReg_i)          w_next_pc = JumpRegTarget_i;
        else if (Jump_i)        w_next_pc = JumpTarget_i;
        else if (BranchTaken_i) w_next_pc = BranchTarget_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= c_nop;
            r_pc4      <= '0;
            r_valid    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            // A redirect must reach the PC even while decode is stalled.
            if (w_redirect || !Stall_i) begin
                r_pc <= w_next_pc;
                if (!w_next_legal)
                    r_addr_err <= 1'b1;
            end

            if (Flush_i) begin
                r_instr <= c_nop;
                r_pc4   <= '0;
                r_valid <= 1'b0;
            end else if (Stall_i) begin
                r_instr <= r_instr;
            end else if (w_redirect || !w_pc_legal) begin
                // Wrong-path slot or a fetch from an illegal address becomes a bubble.
                r_instr <= c_nop;
                r_pc4   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_instr <= Instruction_i;
                r_pc4   <= w_pc_plus4;
                r_valid <= 1'b1;
            end
        end
    end

    assign PC_o                = r_pc;
    assign IF_ID_Instruction_o = r_instr;
    assign IF_ID_PC4_o         = r_pc4;
    assign IF_ID_Valid_o       = r_valid;
    assign AddressError_o      = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed plus randomized self-checking bench for fetch_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_rst_pc = 32'h0040_0000;
    localparam int          c_depth  = 'h200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall_i = 1'b0, Flush_i = 1'b0;
    logic        BranchTaken_i = 1'b0, Jump_i = 1'b0, JumpReg_i = 1'b0;
    logic [31:0] BranchTarget_i = '0, JumpTarget_i = '0, JumpRegTarget_i = '0;
    logic [31:0] Instruction_i;
    logic [31:0] PC_o, IF_ID_Instruction_o, IF_ID_PC4_o;
    logic        IF_ID_Valid_o, AddressError_o;

    logic        fixed_mode = 1'b1;
    logic        check_en   = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Behavioural view of the stage's architectural state.
    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid, m_err, m_pc4_known;

    always #5 clk = ~clk;

    // Program memory stand-in: a fixed opcode or a PC-dependent pattern.
    assign Instruction_i = fixed_mode ? 32'h2008_0001 : ((PC_o * 32'h9E37_79B1) ^ 32'hC0DE_0000);

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (Stall_i),
        .Flush_i             (Flush_i),
        .BranchTaken_i       (BranchTaken_i),
        .BranchTarget_i      (BranchTarget_i),
        .Jump_i              (Jump_i),
        .JumpTarget_i        (JumpTarget_i),
        .JumpReg_i           (JumpReg_i),
        .JumpRegTarget_i     (JumpRegTarget_i),
        .Instruction_i       (Instruction_i),
        .PC_o                (PC_o),
        .IF_ID_Instruction_o (IF_ID_Instruction_o),
        .IF_ID_PC4_o         (IF_ID_PC4_o),
        .IF_ID_Valid_o       (IF_ID_Valid_o),
        .AddressError_o      (AddressError_o)
    );

    function automatic logic legal(input logic [31:0] a);
        return ((a - c_rst_pc) < 32'(4 * c_depth)) && (a % 4 == 0);
    endfunction

    always @(posedge clk) begin
        logic        redirect;
        logic [31:0] target;
        if (reset) begin
            m_pc = c_rst_pc; m_ins = 0; m_pc4 = 0; m_valid = 0; m_err = 0; m_pc4_known = 1;
        end else begin
            redirect = JumpReg_i || Jump_i || BranchTaken_i;
            target   = JumpReg_i ? JumpRegTarget_i : Jump_i ? JumpTarget_i :
                       BranchTaken_i ? BranchTarget_i : m_pc + 32'd4;
            if (Flush_i) begin
                m_ins = 0; m_pc4 = 0; m_valid = 0; m_pc4_known = 1;
            end else if (!Stall_i) begin
                if (redirect || !legal(m_pc)) begin
                    m_ins = 0; m_valid = 0; m_pc4_known = 0;
                end else begin
                    m_ins = Instruction_i; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc4_known = 1;
                end
            end
            if (redirect || !Stall_i) begin
                m_pc = target;
                if (!legal(target)) m_err = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_pc",    PC_o, m_pc);
            chk("cmp_instr", IF_ID_Instruction_o, m_ins);
            chk("cmp_valid", 32'(IF_ID_Valid_o), 32'(m_valid));
            chk("cmp_err",   32'(AddressError_o), 32'(m_err));
            if (m_pc4_known) chk("cmp_pc4", IF_ID_PC4_o, m_pc4);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redirects();
        BranchTaken_i = 0; Jump_i = 0; JumpReg_i = 0;
    endtask

    function automatic logic [31:0] rnd_tgt();
        int unsigned r;
        r = $urandom_range(0, 11);
        if (r == 0) return $urandom;
        if (r == 1) return c_rst_pc + 4 * $urandom_range(0, c_depth - 1) + $urandom_range(1, 3);
        if (r == 2) return 32'hFFFF_FFFC;
        if (r == 3) return c_rst_pc + 32'h7F8;
        return c_rst_pc + 4 * $urandom_range(0, c_depth - 1);
    endfunction

    initial begin
        // Reset and free-running fetch.
        reset = 1; cyc(); check_en = 1;
        chk("rst_pc", PC_o, 32'h0040_0000);
        chk("rst_valid", 32'(IF_ID_Valid_o), 0);
        chk("rst_pc4", IF_ID_PC4_o, 0);
        chk("rst_instr", IF_ID_Instruction_o, 0);
        chk("rst_err", 32'(AddressError_o), 0);
        reset = 0; cyc();
        chk("seq_pc1", PC_o, 32'h0040_0004);
        chk("seq_valid1", 32'(IF_ID_Valid_o), 1);
        chk("seq_pc4_1", IF_ID_PC4_o, 32'h0040_0004);
        chk("seq_instr1", IF_ID_Instruction_o, 32'h2008_0001);
        cyc(); chk("seq_pc2", PC_o, 32'h0040_0008); chk("seq_pc4_2", IF_ID_PC4_o, 32'h0040_0008);
        cyc(); chk("seq_pc3", PC_o, 32'h0040_000C);
        cyc(); chk("seq_pc4", PC_o, 32'h0040_0010);

        // Taken branch.
        BranchTaken_i = 1; BranchTarget_i = 32'h0040_0100; cyc(); clr_redirects();
        chk("br_pc", PC_o, 32'h0040_0100);
        chk("br_bubble", 32'(IF_ID_Valid_o), 0);
        cyc();
        chk("br_pc4", IF_ID_PC4_o, 32'h0040_0104);
        chk("br_valid", 32'(IF_ID_Valid_o), 1);

        // Redirect priority.
        JumpReg_i = 1; JumpRegTarget_i = 32'h0040_0200;
        Jump_i = 1; JumpTarget_i = 32'h0040_0300;
        BranchTaken_i = 1; BranchTarget_i = 32'h0040_0400;
        cyc(); clr_redirects();
        chk("prio_pc", PC_o, 32'h0040_0200);
        Jump_i = 1; JumpTarget_i = 32'h0040_0200; BranchTaken_i = 1; cyc(); clr_redirects();
        chk("prio_j_pc", PC_o, 32'h0040_0200);

        // Stall, then a redirect that wins over the stall.
        Jump_i = 1; JumpTarget_i = 32'h0040_001C; cyc(); clr_redirects();
        cyc(); chk("pre_stall_pc", PC_o, 32'h0040_0020);
        Stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", PC_o, 32'h0040_0020);
            chk("stall_pc4", IF_ID_PC4_o, 32'h0040_0020);
            chk("stall_valid", 32'(IF_ID_Valid_o), 1);
        end
        Jump_i = 1; JumpTarget_i = 32'h0040_0040; cyc(); clr_redirects();
        chk("stall_jmp_pc", PC_o, 32'h0040_0040);
        chk("stall_jmp_hold", IF_ID_PC4_o, 32'h0040_0020);
        Stall_i = 0;

        // Illegal fetch address and sticky error.
        Jump_i = 1; JumpTarget_i = 32'h0040_0802; cyc(); clr_redirects();
        chk("bad_pc", PC_o, 32'h0040_0802);
        chk("bad_err", 32'(AddressError_o), 1);
        chk("bad_valid", 32'(IF_ID_Valid_o), 0);
        cyc(); chk("bad_valid2", 32'(IF_ID_Valid_o), 0);
        Jump_i = 1; JumpTarget_i = 32'h0040_0000; cyc(); clr_redirects();
        cyc();
        chk("resume_pc", PC_o, 32'h0040_0004);
        chk("resume_valid", 32'(IF_ID_Valid_o), 1);
        chk("sticky_err", 32'(AddressError_o), 1);

        // Flush during stall, then reset during stall.
        Stall_i = 1; Flush_i = 1; cyc(); Flush_i = 0;
        chk("flush_pc", PC_o, 32'h0040_0004);
        chk("flush_valid", 32'(IF_ID_Valid_o), 0);
        chk("flush_pc4", IF_ID_PC4_o, 0);
        Jump_i = 1; JumpTarget_i = 32'h0040_0300; reset = 1; cyc(); clr_redirects();
        chk("rst2_pc", PC_o, 32'h0040_0000);
        chk("rst2_err", 32'(AddressError_o), 0);
        reset = 0; Stall_i = 0;

        // Randomized traffic checked against the model every cycle.
        fixed_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            Stall_i         = ($urandom_range(0, 4) == 0);
            Flush_i         = ($urandom_range(0, 9) == 0);
            BranchTaken_i   = ($urandom_range(0, 9) == 0);
            Jump_i          = ($urandom_range(0, 19) == 0);
            JumpReg_i       = ($urandom_range(0, 19) == 0);
            BranchTarget_i  = rnd_tgt();
            JumpTarget_i    = rnd_tgt();
            JumpRegTarget_i = rnd_tgt();
            cyc();
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC-generation and IF/ID register stage of the MIPS datapath.
- Sits directly upstream of ProgramMemory: drives its byte address and consumes the instruction it returns combinationally.
- Registers that instruction, with PC+4 and a valid bit, into the IF/ID register for decode.
- Handles sequential fetch, branch, jump and jump-register redirects, pipeline stall and flush, and detection of illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0040_0000, text-segment base; PC value after reset.
- MEMORY_DEPTH, 'h200, program memory depth in 32-bit words; defines the legal fetch window.
- DATA_WIDTH, 32, width of addresses and instructions.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall_i  input  1  hold PC and IF/ID contents.
- Flush_i  input  1  squash the instruction entering IF/ID.
- BranchTaken_i  input  1  redirect to BranchTarget_i.
- BranchTarget_i  input  32  branch target byte address.
- Jump_i  input  1  redirect to JumpTarget_i.
- JumpTarget_i  input  32  jump target byte address.
- JumpReg_i  input  1  redirect to JumpRegTarget_i (jr).
- JumpRegTarget_i  input  32  register-supplied target.
- Instruction_i  input  32  instruction returned by ProgramMemory for PC_o.
- PC_o  output  32  current PC; drives ProgramMemory Address.
- IF_ID_Instruction_o  output  32  registered instruction.
- IF_ID_PC4_o  output  32  registered PC+4 of that instruction.
- IF_ID_Valid_o  output  1  IF/ID holds a real instruction.
- AddressError_o  output  1  sticky illegal-fetch flag.

Behaviour:
- Only clock is clk; reset is synchronous and active-high. All state changes occur on the rising edge.
- Reset values:
  - PC_o = RESET_PC.
  - IF_ID_Instruction_o = 32'h0000_0000 (NOP).
  - IF_ID_PC4_o = 0.
  - IF_ID_Valid_o = 0.
  - AddressError_o = 0.
- Reset overrides every other input in the same cycle. A reset asserted mid-redirect or mid-stall discards all pending state.
- NextPC selection, in priority order:
  1. JumpReg_i → JumpRegTarget_i
  2. Jump_i → JumpTarget_i
  3. BranchTaken_i → BranchTarget_i
  4. otherwise PC_o + 4
- The +4 add wraps modulo 2^32 and raises no carry flag.
- PC update: PC_o <= NextPC when not stalled. The PC also updates when stalled if any redirect is asserted: a redirect has priority over Stall_i for the PC.
- IF/ID update, in priority order:
  1. Flush_i=1 (stalled or not): Instruction <= NOP, PC4 <= 0, Valid <= 0.
  2. Stall_i=1 with no flush: all three hold.
  3. Any redirect asserted with no flush: Instruction <= NOP, Valid <= 0. The wrong-path slot is squashed automatically.
  4. Otherwise: Instruction <= Instruction_i, PC4 <= PC_o + 4, Valid <= 1.
- Latency: one cycle from PC_o presentation to the instruction appearing in IF/ID. A redirect asserted in cycle N appears on PC_o in cycle N+1; its instruction is Valid in IF/ID in cycle N+2.
- Legal fetch window: RESET_PC <= addr <= RESET_PC + 4*MEMORY_DEPTH − 4 (default 0x0040_0000..0x0040_07FC), with addr[1:0] == 0.
- Illegal NextPC (misaligned or outside the window) when it would be loaded:
  - PC_o still loads it.
  - AddressError_o <= 1 on the same edge.
  - While PC_o is illegal, IF/ID captures NOP with Valid=0 instead of Instruction_i.
  - AddressError_o stays 1 until reset. A subsequent legal redirect resumes normal fetch but does not clear the flag.
- Simultaneous Stall_i and Flush_i with no redirect: PC holds, IF/ID is flushed.
- Outputs are all registered except PC_o, which is the PC register itself; there is no combinational input-to-output path.

Test Plan:
- Reset then 4 free-running cycles with Instruction_i = 0x2008_0001 → PC_o = 0x0040_0000, 04, 08, 0C. IF_ID_Valid_o rises the cycle after reset release. IF_ID_PC4_o = 0x0040_0004, 08, ….
- At PC 0x0040_0010, pulse BranchTaken_i with BranchTarget_i = 0x0040_0100 → next PC_o = 0x0040_0100 and IF/ID Valid=0 for one cycle. The following cycle IF_ID_PC4_o = 0x0040_0104.
- Assert JumpReg_i (0x0040_0200), Jump_i (0x0040_0300) and BranchTaken_i (0x0040_0400) together → PC_o = 0x0040_0200.
- Stall_i high for 3 cycles at PC 0x0040_0020 → PC_o and all IF/ID outputs frozen. Then in one stalled cycle assert Jump_i to 0x0040_0040 → PC_o = 0x0040_0040 next cycle.
- Jump_i to 0x0040_0802 (misaligned and out of range) → AddressError_o = 1 next cycle and IF/ID Valid = 0. A later jump to 0x0040_0000 resumes fetch while AddressError_o stays 1 until reset.
- Flush_i with Stall_i high → IF/ID becomes NOP/Valid=0 and PC holds. Reset asserted mid-stall → all outputs return to their reset values on the next edge.
